// File: rtl/dmem_axil_sram.sv
// -----------------------------------------------------------------------------
// dmem_axil_sram
// AXI4-Lite-style data-memory responder serving LSU load/store traffic.
// Read (AR/R) and write (AW/W/B) channels are run by independent FSMs over a
// shared word-organised SRAM array with byte strobes. Each request waits a
// programmable number of cycles (LAT) before its response is produced.
//
// Optional build macro: DMEM_RAND_DELAY_EN
//   When defined, a 4-bit LFSR (x^4+x^3+1, seed 4'b1001) adds 0..3 extra
//   wait cycles per accepted request. When undefined, latency is exactly LAT.
//
// Parameters
//   BASE_ADDR : byte address of word 0
//   DEPTH     : number of 32-bit words
//   LAT       : wait cycles between request acceptance and response (0..15)
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   araddr/arvalid/arready        : read address channel
//   rdata/rresp/rvalid/rready     : read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready        : write address channel
//   wdata/wstrb/wvalid/wready     : write data channel
//   bresp/bvalid/bready           : write response channel
// -----------------------------------------------------------------------------
module dmem_axil_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LAT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Storage: not reset, read through a registered port.
    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Latency load value (optionally randomised)
    // ------------------------------------------------------------------
    logic [4:0] w_lat_load;

`ifdef DMEM_RAND_DELAY_EN
    logic [3:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 4'b1001;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        end
    end

    // Both channels see the same LFSR value in any given cycle.
    assign w_lat_load = 5'(LAT) + {3'b000, r_lfsr[1:0]};
`else
    assign w_lat_load = 5'(LAT);
`endif

    // ------------------------------------------------------------------
    // Address decode: word offset from BASE_ADDR; low two bits dropped.
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    // ------------------------------------------------------------------
    logic [31:0] w_ar_word;
    logic [31:0] w_aw_word;
    logic        w_ar_ok;
    logic        w_aw_ok;

    assign w_ar_word = (araddr - BASE_ADDR) >> 2;
    assign w_aw_word = (awaddr - BASE_ADDR) >> 2;
    assign w_ar_ok   = (w_ar_word < 32'(DEPTH));
    assign w_aw_ok   = (w_aw_word < 32'(DEPTH));

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]    r_rstate;
    logic          r_arready;
    logic          r_rvalid;
    logic [1:0]    r_rresp;
    logic [4:0]    r_rcnt;
    logic [IW-1:0] r_ar_idx;
    logic          r_ar_ok;
    logic [31:0]   r_rd_word;
    logic          r_rd_ok;
    logic          w_rd_sample;

    assign w_rd_sample = (r_rstate == R_WAIT) && (r_rcnt == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rcnt    <= 5'd0;
            r_ar_idx  <= '0;
            r_ar_ok   <= 1'b0;
            r_rd_ok   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_ar_idx  <= w_ar_word[IW-1:0];
                        r_ar_ok   <= w_ar_ok;
                        r_rcnt    <= w_lat_load;
                        r_arready <= 1'b0;
                        r_rstate  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == 5'd0) begin
                        r_rd_ok  <= r_ar_ok;
                        r_rresp  <= r_ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_rcnt <= r_rcnt - 5'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Registered array read, kept free of reset so it maps onto RAM output
    // registers. A same-cycle commit to this word is not visible here, so a
    // colliding read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_rd_sample) begin
            r_rd_word <= r_mem[r_ar_idx];
        end
    end

    // r_rd_ok is reset, so rdata reads 0 after reset and for out-of-range reads.
    assign rdata   = r_rd_ok ? r_rd_word : 32'h0;
    assign rresp   = r_rresp;
    assign rvalid  = r_rvalid;
    assign arready = r_arready;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]    r_wstate;
    logic          r_awready;
    logic          r_wready;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic [4:0]    r_wcnt;
    logic [IW-1:0] r_aw_idx;
    logic          r_aw_ok;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          w_aw_have;
    logic          w_w_have;
    logic          w_wr_commit;

    // A beat is "held" once latched (its ready is low) or if it arrives now.
    assign w_aw_have   = !r_awready || awvalid;
    assign w_w_have    = !r_wready  || wvalid;
    assign w_wr_commit = (r_wstate == W_WAIT) && (r_wcnt == 5'd0) && r_aw_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wcnt    <= 5'd0;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid && r_awready) begin
                        r_aw_idx  <= w_aw_word[IW-1:0];
                        r_aw_ok   <= w_aw_ok;
                        r_awready <= 1'b0;
                    end
                    if (wvalid && r_wready) begin
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb;
                        r_wready <= 1'b0;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_wcnt   <= w_lat_load;
                        r_wstate <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (r_wcnt == 5'd0) begin
                        r_bresp  <= r_aw_ok ? RESP_OKAY : RESP_SLVERR;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - 5'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane commit; out-of-range writes never reach the array.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bresp   = r_bresp;
    assign bvalid  = r_bvalid;
    assign awready = r_awready;
    assign wready  = r_wready;

endmodule

// File: tb/tb_dmem_axil_sram.sv
// -----------------------------------------------------------------------------
// tb_dmem_axil_sram
// Scoreboard bench for dmem_axil_sram: driver tasks push the hand-computed
// expected response of each transaction into a queue; a monitor running on
// the falling clock edge pops and compares whenever a response handshakes,
// and also checks response latency against the channel's handshake cycle.
// -----------------------------------------------------------------------------
module tb_dmem_axil_sram;

    localparam int LAT = 1;
`ifdef DMEM_RAND_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t rq[$];
    exp_t bq[$];

    dmem_axil_sram #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH     (4096),
        .LAT       (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    int   ar_hs = 0;
    int   w_hs  = 0;
    logic prev_rv = 1'b0;
    logic prev_bv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 1'b0;
            prev_bv = 1'b0;
        end else begin
            int   lat;
            exp_t e;
            if (arvalid && arready) ar_hs = cyc;
            if ((awvalid && awready) || (wvalid && wready)) w_hs = cyc;
            if (rvalid && !prev_rv) begin
                lat = cyc - ar_hs - 1;
                checks++;
                if (lat < LAT + 1 || lat > LAT + 1 + EXTRA) begin
                    errors++;
                    $display("FAIL r_latency: got %0d expected %0d..%0d", lat, LAT + 1, LAT + 1 + EXTRA);
                end
            end
            if (bvalid && !prev_bv) begin
                lat = cyc - w_hs - 1;
                checks++;
                if (lat < LAT + 1 || lat > LAT + 1 + EXTRA) begin
                    errors++;
                    $display("FAIL b_latency: got %0d expected %0d..%0d", lat, LAT + 1, LAT + 1 + EXTRA);
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rvalid=1 expected no response");
                end else begin
                    e = rq.pop_front();
                    $display("READ  rdata=0x%08h rresp=%0d", rdata, rresp);
                    check("rdata", rdata, e.data);
                    check("rresp", 32'(rresp), 32'(e.resp));
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bvalid=1 expected no response");
                end else begin
                    e = bq.pop_front();
                    $display("WRITE bresp=%0d", bresp);
                    check("bresp", 32'(bresp), 32'(e.resp));
                end
            end
            prev_rv = rvalid;
            prev_bv = bvalid;
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        rq.push_back('{data: d, resp: r});
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; ; n++) begin
            if (n >= 200) begin
                check("ar_timeout", 32'd1, 32'd0);
                break;
            end
            if (arready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r, input int wdly);
        logic aw_hit;
        logic w_hit;
        bq.push_back('{data: 32'h0, resp: r});
        @(posedge clk); #1;
        awaddr  = a;
        awvalid = 1'b1;
        wdata   = d;
        wstrb   = s;
        wvalid  = (wdly == 0);
        for (int n = 0; ; n++) begin
            if (n >= 200) begin
                check("aw_w_timeout", 32'd1, 32'd0);
                break;
            end
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hit) awvalid = 1'b0;
            if (w_hit)  wvalid  = 1'b0;
            if (n + 1 == wdly) wvalid = 1'b1;
            if (!awvalid && !wvalid && n + 1 >= wdly) break;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (rq.size() == 0 && bq.size() == 0 && arready && awready && wready) break;
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic seen_rv;
        rst     = 1'b1;
        araddr  = 32'h0;
        arvalid = 1'b0;
        rready  = 1'b1;
        awaddr  = 32'h0;
        awvalid = 1'b0;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready",  32'(wready),  32'd1);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'h0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);

        // Full word write/read
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
        rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // Byte strobes: lanes 0 and 2 replaced
        wr(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 0);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
        rd(32'h8000_0020, 32'h11BB_33DD, 2'b00);

        // W arrives two cycles after AW; addr[1:0] ignored
        wr(32'h8000_0042, 32'hCAFE_F00D, 4'hF, 2'b00, 2);
        rd(32'h8000_0040, 32'hCAFE_F00D, 2'b00);

        // Empty strobe: OKAY, array unchanged
        wr(32'h8000_0010, 32'h0000_0000, 4'h0, 2'b00, 0);
        rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // Last word in range
        wr(32'h8000_3FFC, 32'h1234_5678, 4'hF, 2'b00, 0);
        rd(32'h8000_3FFC, 32'h1234_5678, 2'b00);

        // Out of range read below base, and write just past the top
        rd(32'h7FFF_FFFC, 32'h0, 2'b10);
        wr(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 2'b00, 0);
        wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
        rd(32'h8000_0000, 32'h0BAD_F00D, 2'b00);
        wait_idle();

        // Backpressure: hold rready low for 5 cycles after rvalid
        rready = 1'b0;
        rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        for (int n = 0; n < 50 && !rvalid; n++) begin
            @(posedge clk); #1;
        end
        check("bp_rvalid_seen", 32'(rvalid), 32'd1);
        for (int n = 0; n < 5; n++) begin
            check("bp_rvalid_held", 32'(rvalid), 32'd1);
            check("bp_rdata_held",  rdata,       32'hDEAD_BEEF);
            check("bp_arready_low", 32'(arready), 32'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        check("bp_rvalid_drop", 32'(rvalid),  32'd0);
        check("bp_arready_up",  32'(arready), 32'd1);

        // Same-word race: read and write in the same cycle see old data
        wr(32'h8000_0030, 32'h0000_0005, 4'hF, 2'b00, 0);
        wait_idle();
        fork
            rd(32'h8000_0030, 32'h0000_0005, 2'b00);
            wr(32'h8000_0030, 32'h0000_0009, 4'hF, 2'b00, 0);
        join
        rd(32'h8000_0030, 32'h0000_0009, 2'b00);
        wait_idle();
        check("queues_empty", 32'(rq.size() + bq.size()), 32'd0);

        // Reset during R_WAIT aborts the read without a response
        @(posedge clk); #1;
        araddr  = 32'h8000_0010;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_arready", 32'(arready), 32'd1);
        seen_rv = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (rvalid) seen_rv = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_rvalid", 32'(seen_rv), 32'd0);

        // Array survives reset
        rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        wait_idle();
        check("final_queues_empty", 32'(rq.size() + bq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
